// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//   Shared types and constants for the two-master data-memory arbiter.
//   - arb_state_e : bus ownership state (FREE, LOCK0, LOCK1)
//   - M0 / M1     : master identifiers as stored in the read-return tag
//   - ACT / IDLE  : levels of the RAM's active-low control pins
//   - pick_grant  : one-cycle grant decision, returned as {m1_gnt, m0_gnt}
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      FREE  = 2'd0,
      LOCK0 = 2'd1,
      LOCK1 = 2'd2
   } arb_state_e;

   localparam logic M0 = 1'b0;
   localparam logic M1 = 1'b1;

   localparam logic ACT  = 1'b0;
   localparam logic IDLE = 1'b1;

   // Master 0 normally wins. Master 1 wins when it is alone, or when it has
   // been denied long enough to be marked starved. A locked bus only serves
   // its owner; the other master waits regardless of starvation.
   function automatic logic [1:0] pick_grant(
      input arb_state_e state,
      input logic       m0_req,
      input logic       m1_req,
      input logic       m1_starved
   );
      logic [1:0] gnt;
      gnt = 2'b00;
      case (state)
         LOCK0:   gnt = {1'b0, m0_req};
         LOCK1:   gnt = {m1_req, 1'b0};
         default: begin
            if (m1_req && (m1_starved || !m0_req)) begin
               gnt = 2'b10;
            end else if (m0_req) begin
               gnt = 2'b01;
            end
         end
      endcase
      return gnt;
   endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Two-master arbiter and sequencer for one RAM2Kx32. At most one access is
//   issued per cycle; read data comes back one cycle after its grant.
//   Master 0 has fixed priority, master 1 is forced through after STARVE_MAX
//   consecutive denied cycles, and a master may lock the bus for multi-word
//   sequences, bounded to LOCK_MAX cycles.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mX_req/we/lock           request, 1 = write, keep ownership after access
//   mX_addr/wdata            word address and write data (held while waiting)
//   mX_gnt                   combinational grant; access issues at this edge
//   mX_rvalid/rdata          read return one cycle after a read grant
//   mem_cen/wen/oen          RAM controls, active-low
//   mem_a/mem_d/mem_q        RAM address, write data, read data
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = 8,
   parameter int LOCK_MAX   = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic              m0_lock,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic              m1_lock,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic [DATA_W-1:0] m1_rdata,
   output logic              mem_cen,
   output logic              mem_wen,
   output logic              mem_oen,
   output logic [ADDR_W-1:0] mem_a,
   output logic [DATA_W-1:0] mem_d,
   input  logic [DATA_W-1:0] mem_q
);

   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam int LW = $clog2(LOCK_MAX + 1);
   localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
   // A lock is released on the edge that would take the cycle count to
   // LOCK_MAX, so the owner holds the bus for exactly LOCK_MAX cycles.
   localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCK_MAX - 1);

   arb_state_e        state_q, state_d;
   logic [SW-1:0]     starve_cnt_q, starve_cnt_d;
   logic [LW-1:0]     lock_cnt_q, lock_cnt_d;
   logic              rd_pend_q, rd_pend_d;
   logic              rd_id_q, rd_id_d;

   logic [1:0]        gnt;
   logic              gnt_any;
   logic              gnt_id;
   logic              gnt_we;
   logic              gnt_lock;
   logic              lock_expire;

   // ---------------------------------------------------------------------------
   // Grant and RAM drive (combinational, same cycle as the request)
   // ---------------------------------------------------------------------------
   // NOTE: every signal written here gets a default first, so no path leaves
   // it unassigned and no latch is inferred.
   always_comb begin : grant_and_drive
      gnt = 2'b00;
      // Grants are held low during reset even with requests present.
      if (!rst) begin
         gnt = pick_grant(state_q, m0_req, m1_req, starve_cnt_q == STARVE_TOP);
      end

      gnt_any  = |gnt;
      gnt_id   = gnt[1] ? M1 : M0;
      gnt_we   = gnt[1] ? m1_we   : m0_we;
      gnt_lock = gnt[1] ? m1_lock : m0_lock;

      mem_cen = IDLE;
      mem_wen = IDLE;
      mem_a   = '0;
      mem_d   = '0;
      if (gnt_any) begin
         mem_cen = ACT;
         mem_wen = gnt_we ? ACT : IDLE;
         mem_a   = gnt[1] ? m1_addr  : m0_addr;
         mem_d   = gnt[1] ? m1_wdata : m0_wdata;
      end
   end

   assign m0_gnt = gnt[0];
   assign m1_gnt = gnt[1];

   // ---------------------------------------------------------------------------
   // Ownership, starvation and read-return bookkeeping
   // ---------------------------------------------------------------------------
   always_comb begin : next_state
      state_d     = state_q;
      lock_cnt_d  = lock_cnt_q;
      lock_expire = (state_q != FREE) && (lock_cnt_q == LOCK_LAST);

      case (state_q)
         FREE: begin
            lock_cnt_d = '0;
            if (gnt_any && gnt_lock) begin
               state_d = (gnt_id == M1) ? LOCK1 : LOCK0;
            end
         end
         LOCK0, LOCK1: begin
            lock_cnt_d = lock_cnt_q + 1'b1;
            // Only the owner can be granted here, so any grant is the owner's.
            // Timeout wins over a lock=1 access in the same cycle.
            if (lock_expire || (gnt_any && !gnt_lock)) begin
               state_d    = FREE;
               lock_cnt_d = '0;
            end
         end
         default: begin
            state_d    = FREE;
            lock_cnt_d = '0;
         end
      endcase

      // Counts consecutive denied m1 cycles, also while m0 holds a lock.
      starve_cnt_d = '0;
      if (m1_req && !m1_gnt) begin
         starve_cnt_d = (starve_cnt_q == STARVE_TOP) ? STARVE_TOP
                                                     : starve_cnt_q + 1'b1;
      end

      rd_pend_d = gnt_any && !gnt_we;
      rd_id_d   = rd_pend_d ? gnt_id : rd_id_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples its _d value from before this edge, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= FREE;
         starve_cnt_q <= '0;
         lock_cnt_q   <= '0;
         rd_pend_q    <= 1'b0;
         rd_id_q      <= M0;
      end else begin
         state_q      <= state_d;
         starve_cnt_q <= starve_cnt_d;
         lock_cnt_q   <= lock_cnt_d;
         rd_pend_q    <= rd_pend_d;
         rd_id_q      <= rd_id_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Read return: gated by rst so a read pending across reset is dropped.
   // ---------------------------------------------------------------------------
   assign m0_rvalid = !rst && rd_pend_q && (rd_id_q == M0);
   assign m1_rvalid = !rst && rd_pend_q && (rd_id_q == M1);
   assign mem_oen   = (!rst && rd_pend_q) ? ACT : IDLE;
   assign m0_rdata  = mem_q;
   assign m1_rdata  = mem_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

   localparam int ADDR_W     = 11;
   localparam int DATA_W     = 32;
   localparam int STARVE_MAX = 8;
   localparam int LOCK_MAX   = 16;
   localparam int DEPTH      = 2 ** ADDR_W;

   logic              clk = 1'b0;
   logic              rst;
   logic              m0_req, m0_we, m0_lock, m1_req, m1_we, m1_lock;
   logic [ADDR_W-1:0] m0_addr, m1_addr, mem_a;
   logic [DATA_W-1:0] m0_wdata, m1_wdata, m0_rdata, m1_rdata, mem_d, mem_q;
   logic              m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
   logic              mem_cen, mem_wen, mem_oen;

   always #5 clk = ~clk;

   dmem_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .LOCK_MAX(LOCK_MAX)
   ) dut (
      .clk(clk), .rst(rst),
      .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
      .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
      .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
      .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_oen(mem_oen),
      .mem_a(mem_a), .mem_d(mem_d), .mem_q(mem_q)
   );

   // Behavioural RAM2Kx32: synchronous write, registered read.
   logic [DATA_W-1:0] ram [DEPTH];
   always @(posedge clk) begin
      if (!mem_cen) begin
         if (!mem_wen) ram[mem_a] <= mem_d;
         else          mem_q      <= ram[mem_a];
      end
   end

   // Requester state: one pending request per master, held until granted.
   typedef struct {
      bit                req;
      bit                we;
      bit                lock;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } rq_t;
   rq_t rq [2];

   // Scoreboard entry: which master should see which data on which cycle.
   typedef struct {
      int                due;
      int                id;
      logic [DATA_W-1:0] data;
   } rd_exp_t;
   rd_exp_t rd_q [$];

   logic [DATA_W-1:0] ref_mem [DEPTH];

   // Reference model state: lock owner (-1 = nobody), cycles the lock has
   // been held, consecutive cycles m1 has waited, read issued last cycle.
   int owner     = -1;
   int held      = 0;
   int m1_wait   = 0;
   bit prev_read = 1'b0;
   bit obs_gnt [2];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic set_rq(input int m, input bit we, input bit lock, input int addr,
                         input logic [DATA_W-1:0] d);
      rq[m].req   = 1'b1;
      rq[m].we    = we;
      rq[m].lock  = lock;
      rq[m].addr  = ADDR_W'(addr);
      rq[m].wdata = d;
   endtask

   // One clock cycle: drive, predict, compare at negedge, advance model.
   task automatic step();
      int                g;
      bit                g_we, g_lock;
      logic [ADDR_W-1:0] g_addr;
      logic [DATA_W-1:0] g_data;

      m0_req = rq[0].req; m0_we = rq[0].we; m0_lock = rq[0].lock;
      m0_addr = rq[0].addr; m0_wdata = rq[0].wdata;
      m1_req = rq[1].req; m1_we = rq[1].we; m1_lock = rq[1].lock;
      m1_addr = rq[1].addr; m1_wdata = rq[1].wdata;

      @(negedge clk);
      g = -1;
      if (!rst) begin
         if (owner >= 0) begin
            if (rq[owner].req) g = owner;
         end else if (rq[1].req && (m1_wait >= STARVE_MAX || !rq[0].req)) begin
            g = 1;
         end else if (rq[0].req) begin
            g = 0;
         end
      end
      g_we = 1'b0; g_lock = 1'b0; g_addr = '0; g_data = '0;
      if (g >= 0) begin
         g_we = rq[g].we; g_lock = rq[g].lock; g_addr = rq[g].addr; g_data = rq[g].wdata;
      end

      obs_gnt[0] = m0_gnt;
      obs_gnt[1] = m1_gnt;
      check("m0_gnt",  m0_gnt,  g == 0);
      check("m1_gnt",  m1_gnt,  g == 1);
      check("mem_cen", mem_cen, g < 0);
      check("mem_wen", mem_wen, (g < 0) || !g_we);
      check("mem_a",   mem_a,   g_addr);
      check("mem_d",   mem_d,   g_data);
      check("mem_oen", mem_oen, !(prev_read && !rst));
      if (rst) check("rvalid_in_reset", {m1_rvalid, m0_rvalid}, 2'b00);

      if (g >= 0) begin
         if (g_we) ref_mem[g_addr] = g_data;
         else      rd_q.push_back('{due: cyc + 1, id: g, data: ref_mem[g_addr]});
      end

      if (rst) begin
         owner = -1; held = 0; m1_wait = 0; prev_read = 1'b0;
      end else begin
         if (rq[1].req && g != 1) m1_wait = (m1_wait < STARVE_MAX) ? m1_wait + 1 : STARVE_MAX;
         else                     m1_wait = 0;
         if (owner >= 0) begin
            held++;
            if (held == LOCK_MAX)           owner = -1;
            else if (g == owner && !g_lock) owner = -1;
         end else if (g >= 0 && g_lock) begin
            owner = g;
            held  = 0;
         end
         prev_read = (g >= 0) && !g_we;
         if (g >= 0) rq[g].req = 1'b0;
      end

      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic reset_cycle();
      rst = 1'b1;
      rd_q.delete();
      step();
      rst = 1'b0;
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && (rq[0].req || rq[1].req); k++) step();
   endtask

   function automatic int pick_addr();
      if ($urandom_range(0, 3) == 0) return 'h7FC + int'($urandom_range(0, 3));
      return int'($urandom_range(0, 15));
   endfunction

   // Monitor: every rvalid must match the oldest expected read, on time.
   always @(negedge clk) begin
      rd_exp_t e;
      if (m0_rvalid || m1_rvalid) begin
         check("rvalid_count", 32'(m0_rvalid) + 32'(m1_rvalid), 1);
         if (rd_q.size() == 0 || rd_q[0].due != cyc) begin
            check("rvalid_unexpected", {m1_rvalid, m0_rvalid}, 2'b00);
         end else begin
            e = rd_q.pop_front();
            check("rvalid_id", {m1_rvalid, m0_rvalid}, (e.id == 1) ? 2'b10 : 2'b01);
            check("rdata", (e.id == 1) ? m1_rdata : m0_rdata, e.data);
         end
      end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
         e = rd_q.pop_front();
         check("rvalid_missing", {m1_rvalid, m0_rvalid}, (e.id == 1) ? 2'b10 : 2'b01);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int m1_cnt;
      int waited;

      for (int i = 0; i < DEPTH; i++) begin
         ram[i]     = '0;
         ref_mem[i] = '0;
      end
      ram[5]     = 32'hDEAD_BEEF;
      ref_mem[5] = 32'hDEAD_BEEF;
      for (int m = 0; m < 2; m++) rq[m] = '{req: 0, we: 0, lock: 0, addr: '0, wdata: '0};

      // Reset state, including requests present during reset.
      rst = 1'b1;
      step();
      set_rq(0, 1'b0, 1'b0, 3, 0);
      step();
      rst = 1'b0;
      step();
      step();

      // Uncontended read from m1.
      reset_cycle();
      set_rq(1, 1'b0, 1'b0, 'h005, 0);
      step();
      check("uc_m1_gnt", obs_gnt[1], 1'b1);
      step();

      // Full contention: m1 forced through every STARVE_MAX + 1 cycles.
      reset_cycle();
      m1_cnt = 0;
      for (int i = 0; i < 3 * (STARVE_MAX + 1); i++) begin
         for (int m = 0; m < 2; m++)
            if (!rq[m].req) set_rq(m, 1'($urandom), 1'b0, pick_addr(), $urandom);
         step();
         check("cont_m1_slot", obs_gnt[1], (i % (STARVE_MAX + 1)) == STARVE_MAX);
         m1_cnt += int'(obs_gnt[1]);
      end
      check("cont_m1_total", m1_cnt, 3);
      drain();

      // Four-word locked burst from m1 while m0 waits.
      reset_cycle();
      set_rq(1, 1'b1, 1'b1, 'h100, 32'hA000_0000);
      step();
      check("lock_first_m1", obs_gnt[1], 1'b1);
      for (int k = 1; k < 4; k++) begin
         set_rq(1, 1'b1, k < 3, 'h100 + k, 32'hA000_0000 + k);
         if (!rq[0].req) set_rq(0, 1'b0, 1'b0, 'h010, 0);
         step();
         check("lock_m0_held", obs_gnt[0], 1'b0);
         check("lock_m1_gnt", obs_gnt[1], 1'b1);
      end
      step();
      check("lock_release_m0", obs_gnt[0], 1'b1);
      set_rq(1, 1'b0, 1'b0, 'h102, 0);
      step();
      step();

      // Lock timeout: m0 locks then goes quiet.
      reset_cycle();
      set_rq(0, 1'b1, 1'b1, 'h020, 32'h0000_0055);
      step();
      set_rq(1, 1'b0, 1'b0, 'h020, 0);
      waited = 0;
      for (int k = 0; k < LOCK_MAX + 4; k++) begin
         step();
         if (obs_gnt[1]) break;
         waited++;
      end
      check("lock_timeout_wait", waited, LOCK_MAX);
      drain();
      step();

      // Write then read of the top address on consecutive cycles.
      set_rq(0, 1'b1, 1'b0, 'h7FF, 32'h1234_5678);
      step();
      set_rq(1, 1'b0, 1'b0, 'h7FF, 0);
      step();
      step();

      // Reset in the cycle after a read grant drops the read.
      set_rq(0, 1'b0, 1'b0, 'h005, 0);
      step();
      check("rst_read_gnt", obs_gnt[0], 1'b1);
      reset_cycle();
      step();

      // Randomized traffic with occasional locks and one mid-run reset.
      for (int i = 0; i < 1500; i++) begin
         for (int m = 0; m < 2; m++)
            if (!rq[m].req && $urandom_range(0, 99) < 60)
               set_rq(m, 1'($urandom), $urandom_range(0, 5) == 0, pick_addr(), $urandom);
         if (i == 700) reset_cycle();
         else          step();
      end
      drain();
      step();
      step();
      check("rd_queue_empty", rd_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-master arbiter and sequencer for one RAM2Kx32 instance, such as the data memory behind the pipeline. Master 0 is the pipeline's data port. Master 1 is a loader/debug port that reads and writes memory while the core runs or is halted. The block grants at most one access per cycle and drives the RAM's active-low CEN/WEN/OEN controls. It returns read data one cycle after grant, with fixed priority to master 0, a starvation guard for master 1, and bounded bus locks for multi-word sequences.

## Interface
- ADDR_W, 11, RAM word-address width
- DATA_W, 32, RAM data width
- STARVE_MAX, 8, consecutive denied m1 request cycles before m1 is forced through (≥1)
- LOCK_MAX, 16, maximum cycles a lock may be held before it is force-released (≥1)

- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-high
- m0_req / m1_req  input  1  access request, held until granted
- m0_we / m1_we  input  1  1 = write, 0 = read
- m0_lock / m1_lock  input  1  keep ownership after this access
- m0_addr / m1_addr  input  ADDR_W  word address
- m0_wdata / m1_wdata  input  DATA_W  write data
- m0_gnt / m1_gnt  output  1  combinational grant; the access is issued at this clock edge
- m0_rvalid / m1_rvalid  output  1  read data valid, one cycle after a read grant
- m0_rdata / m1_rdata  output  DATA_W  mem_q passthrough; meaningful only with rvalid
- mem_cen  output  1  RAM chip enable, active-low
- mem_wen  output  1  RAM write enable, active-low
- mem_oen  output  1  RAM output enable, active-low
- mem_a  output  ADDR_W  RAM address
- mem_d  output  DATA_W  RAM write data
- mem_q  input  DATA_W  RAM read data

## Operation
- **States:** FREE, LOCK0, LOCK1.
- **Grant in FREE:**
  - The m0 request wins.
  - Exception: when starve_cnt == STARVE_MAX and m1_req = 1, m1 wins.
  - m1 also wins when it is the only requester.
- **Grant in LOCKx:** only master x may be granted. The other master's request is held off, but its starvation counting continues for m1.
- **Lock transitions:**
  - A granted access with lock = 1 moves FREE to LOCKx.
  - A granted access with lock = 0 by the owner returns LOCKx to FREE.
  - lock_cnt reaching LOCK_MAX forces FREE on the next edge, regardless of the lock bit.
  - An owner that stops requesting keeps the lock until timeout.
- **starve_cnt:**
  - Increments when m1_req = 1 and m1_gnt = 0, saturating at STARVE_MAX.
  - Clears on m1_gnt or when m1_req = 0.
- **lock_cnt:**
  - Clears on entry to LOCKx.
  - Increments each cycle in LOCKx.
  - Forced FREE has priority over a same-cycle lock = 1 access; that access is still granted.
- **Memory drive when a master is granted:**
  - mem_cen = 0.
  - mem_wen = ~we.
  - mem_a and mem_d come from the granted master.
- **Memory drive with no grant:** mem_cen = 1, mem_wen = 1, mem_a and mem_d = 0.
- **Read return:**
  - A read grant sets rd_pend and rd_id.
  - Next cycle: mem_oen = 0 and mX_rvalid = 1 for the recorded master only.
  - mem_oen = 1 otherwise.
- **Writes:** complete at the grant edge; there is no response.

## Timing
- **Reset values:**
  - gnt, rvalid = 0
  - mem_cen, mem_wen, mem_oen = 1
  - mem_a, mem_d = 0
  - state = FREE; starve_cnt, lock_cnt, rd_pend = 0
- **Reset mid-operation:** a pending read is dropped with no rvalid. Grants are low during the reset cycle, even with requests present.
- **Latency:** grant in cycle N (same cycle as request when uncontended); read data/rvalid in cycle N+1.
- **Throughput:** one access per cycle. Back-to-back reads from alternating masters each get their own rvalid in consecutive cycles.
- **Same-edge write then read:** a write at N followed by a read at N+1 of the same address returns the new data. The RAM write completes at edge N.
- **Worst-case m1 latency under full m0 load:** STARVE_MAX + 1 cycles, plus up to LOCK_MAX if m0 holds a lock.
- **Requester rule:** mX_addr/we/wdata/lock stay stable while req = 1 and gnt = 0. The arbiter does not latch request fields.

## Structure
- **Package dmem_arb_pkg:**
  - state enum {FREE, LOCK0, LOCK1}
  - master-id constants M0 = 1'b0, M1 = 1'b1
  - RAM control polarity constants (ACT = 1'b0, IDLE = 1'b1)
- **Sub-modules:** none required; a single module of about 150–250 lines. An optional grant-pick function lives in the package.

## Test plan
- **Uncontended read:** after reset, m1 reads addr 0x005 (preload 0xDEADBEEF) → m1_gnt the same cycle with mem_cen = 0 and mem_wen = 1; next cycle m1_rvalid = 1, m1_rdata = 0xDEADBEEF, mem_oen = 0.
- **Contention:** m0 and m1 request every cycle with STARVE_MAX = 8 → m0 granted 8 cycles, m1 granted on the 9th, pattern repeats; no cycle grants both.
- **Lock:** m1 writes 0x100..0x103 with lock = 1 on the first three and 0 on the last, while m0 requests → m0_gnt = 0 throughout; FREE after the 4th access; m0 granted the next cycle.
- **Lock timeout:** m0 locks and then drops req with LOCK_MAX = 16 → m1 held off 16 cycles, then granted.
- **Write/read hazard:** m0 writes 0x7FF = 0x12345678, then m1 reads 0x7FF the next cycle → m1_rdata = 0x12345678; the address wraps nowhere (top address valid).
- **Reset mid-read:** rst asserted in the cycle after a read grant → no rvalid; all outputs at reset values the following cycle.
